// File: rtl/calc_pkg.sv
// Shared types and constants for the calculator digit-entry keypad front end.
// Optional macro CALC_BKSP_EN adds the backspace button to the debounced vector.
// Button indices below match the bit order of the debounced press vector.
package calc_pkg;

   localparam int VAL_W     = 14;
   localparam int MAX_VALUE = 9999;

   // Bit positions within the raw / debounced button vector
   localparam int DIG0 = 0;
   localparam int DIG9 = 9;
   localparam int CLR  = 10;
   localparam int ENT  = 11;
   localparam int BKSP = 12;

`ifdef CALC_BKSP_EN
   localparam int BTN_W = 13;
`else
   localparam int BTN_W = 12;
`endif

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ENTRY = 2'd1,
      HOLD  = 2'd2
   } entry_state_t;

   // value*10 + d using shifts; 999*10+9 = 9999 fits in VAL_W bits
   function automatic logic [VAL_W-1:0] times10_add(input logic [VAL_W-1:0] v,
                                                    input logic [3:0]       d);
      return (v << 3) + (v << 1) + {{(VAL_W-4){1'b0}}, d};
   endfunction

endpackage

// File: rtl/calc_debounce.sv
// Debouncer: 2-flop synchronizer, one shared stability counter, 1-cycle press pulses.
// Latency: 2 sync cycles + DEBOUNCE_CYCLES stable cycles, then press pulse for one cycle.
// No backpressure; releases produce no pulse.
module calc_debounce #(
   parameter int W               = 12,
   parameter int DEBOUNCE_CYCLES = 10_000
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [W-1:0] i_raw,
   output logic [W-1:0] o_press
);

   localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [W-1:0]     r_sync1;
   logic [W-1:0]     r_sync2;
   logic [W-1:0]     r_stable;
   logic [W-1:0]     r_stable_q;
   logic [CNT_W-1:0] r_cnt;

   // Bring the asynchronous buttons into the clk domain
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sync1 <= '0;
         r_sync2 <= '0;
      end else begin
         r_sync1 <= i_raw;
         r_sync2 <= r_sync1;
      end
   end

   // Accept a new vector only after it has differed from the stable one long enough
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_stable <= '0;
         r_cnt    <= '0;
      end else if (r_sync2 != r_stable) begin
         if (r_cnt == CNT_LAST) begin
            r_stable <= r_sync2;
            r_cnt    <= '0;
         end else begin
            r_cnt <= r_cnt + 1'b1;
         end
      end else begin
         r_cnt <= '0;
      end
   end

   // Delayed copy for rising-edge detection
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_stable_q <= '0;
      else        r_stable_q <= r_stable;
   end

   assign o_press = r_stable & ~r_stable_q;

endmodule

// File: rtl/calc_digit_entry.sv
// Keypad digit entry: debounced buttons build a 0..9999 operand; enter strobes it out.
// Latency: outputs update on the clock edge after the debounced press pulse.
// No backpressure; entry_valid is a one-cycle strobe. Optional macro: CALC_BKSP_EN.
module calc_digit_entry
   import calc_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 10_000,
   parameter int MAX_DIGITS      = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [9:0]       btn_digit,
   input  logic             btn_clr,
   input  logic             btn_enter,
   input  logic             btn_bksp,
   output logic [VAL_W-1:0] value,
   output logic [2:0]       digit_cnt,
   output logic             full,
   output logic             entry_valid,
   output logic [VAL_W-1:0] entry_value
);

   logic [BTN_W-1:0] w_raw;
   logic [BTN_W-1:0] w_press;

`ifdef CALC_BKSP_EN
   assign w_raw = {btn_bksp, btn_enter, btn_clr, btn_digit};
`else
   logic w_unused_bksp;
   assign w_unused_bksp = btn_bksp;
   assign w_raw = {btn_enter, btn_clr, btn_digit};
`endif

   calc_debounce #(
      .W               (BTN_W),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
   ) u_debounce (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_raw   (w_raw),
      .o_press (w_press)
   );

   entry_state_t     r_state, w_state_nxt;
   logic [VAL_W-1:0] r_value, w_value_nxt;
   logic [2:0]       r_cnt, w_cnt_nxt;
   logic             r_ev, w_ev_nxt;
   logic [VAL_W-1:0] r_ev_value, w_ev_value_nxt;
   logic [9:0]       w_dig;
   logic             w_dig_one;
   logic [3:0]       w_dig_val;

   // Decode digit presses; more than one digit in a cycle is treated as no digit
   always_comb begin
      w_dig     = w_press[DIG9:DIG0];
      w_dig_one = (w_dig != 10'd0) && ((w_dig & (w_dig - 10'd1)) == 10'd0);
      w_dig_val = 4'd0;
      for (int i = 0; i < 10; i++) begin
         if (w_dig[i]) w_dig_val = 4'(i);
      end
   end

   // State and operand registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= EMPTY;
         r_value    <= '0;
         r_cnt      <= '0;
         r_ev       <= 1'b0;
         r_ev_value <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_value    <= w_value_nxt;
         r_cnt      <= w_cnt_nxt;
         r_ev       <= w_ev_nxt;
         r_ev_value <= w_ev_value_nxt;
      end
   end

   // Next state: clr beats enter beats backspace beats digit
   always_comb begin
      w_state_nxt    = r_state;
      w_value_nxt    = r_value;
      w_cnt_nxt      = r_cnt;
      w_ev_nxt       = 1'b0;
      w_ev_value_nxt = r_ev_value;
      if (w_press[CLR]) begin
         w_state_nxt = EMPTY;
         w_value_nxt = '0;
         w_cnt_nxt   = '0;
      end else if (w_press[ENT]) begin
         w_ev_nxt = 1'b1;
         // In HOLD the latched operand is simply re-strobed
         if (r_state != HOLD) w_ev_value_nxt = r_value;
         if (r_state == ENTRY) w_state_nxt = HOLD;
`ifdef CALC_BKSP_EN
      end else if (w_press[BKSP]) begin
         if (r_state == ENTRY) begin
            w_value_nxt = r_value / VAL_W'(10);
            w_cnt_nxt   = r_cnt - 3'd1;
            if (r_cnt == 3'd1) w_state_nxt = EMPTY;
         end
`endif
      end else if (w_dig_one) begin
         if (r_state == ENTRY) begin
            if (r_cnt < 3'(MAX_DIGITS)) begin
               w_value_nxt = times10_add(r_value, w_dig_val);
               w_cnt_nxt   = r_cnt + 3'd1;
            end
         end else if (w_dig_val == 4'd0) begin
            // Leading zero: operand stays empty
            w_state_nxt = EMPTY;
            w_value_nxt = '0;
            w_cnt_nxt   = '0;
         end else begin
            w_state_nxt = ENTRY;
            w_value_nxt = {{(VAL_W-4){1'b0}}, w_dig_val};
            w_cnt_nxt   = 3'd1;
         end
      end
   end

   assign value       = r_value;
   assign digit_cnt   = r_cnt;
   assign full        = (r_cnt == 3'(MAX_DIGITS));
   assign entry_valid = r_ev;
   assign entry_value = r_ev_value;

endmodule

// File: tb/tb_calc_digit_entry.sv
// Directed bench for calc_digit_entry with DEBOUNCE_CYCLES=4.
// Inputs driven on the falling edge, outputs sampled on the falling edge.
// Enter strobes are counted by a monitor sampling just after each rising edge.
module tb_calc_digit_entry;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [9:0]  btn_digit = '0;
   logic        btn_clr = 1'b0;
   logic        btn_enter = 1'b0;
   logic        btn_bksp = 1'b0;
   logic [13:0] value;
   logic [2:0]  digit_cnt;
   logic        full;
   logic        entry_valid;
   logic [13:0] entry_value;

   int total = 0;
   int bad = 0;
   int ev_n = 0;
   int ev_dbl = 0;
   logic ev_prev = 1'b0;
   int e0;

   localparam logic [12:0] B_CLR  = 13'h0400;
   localparam logic [12:0] B_ENT  = 13'h0800;
   localparam logic [12:0] B_BKSP = 13'h1000;

   calc_digit_entry #(
      .DEBOUNCE_CYCLES (4),
      .MAX_DIGITS      (4)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .btn_digit   (btn_digit),
      .btn_clr     (btn_clr),
      .btn_enter   (btn_enter),
      .btn_bksp    (btn_bksp),
      .value       (value),
      .digit_cnt   (digit_cnt),
      .full        (full),
      .entry_valid (entry_valid),
      .entry_value (entry_value)
   );

   always #5 clk = ~clk;

   // Count enter strobes and any back-to-back strobe
   always @(posedge clk) begin
      #1;
      if (entry_valid) begin
         ev_n = ev_n + 1;
         if (ev_prev) ev_dbl = ev_dbl + 1;
      end
      ev_prev = entry_valid;
   end

   task automatic chk(input string tag, input int obs, input int exp);
      total = total + 1;
      if (obs != exp) begin
         bad = bad + 1;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Hold a button vector long enough to debounce, then release it fully
   task automatic press(input logic [12:0] b);
      btn_digit = b[9:0];
      btn_clr   = b[10];
      btn_enter = b[11];
      btn_bksp  = b[12];
      repeat (10) @(negedge clk);
      btn_digit = '0;
      btn_clr   = 1'b0;
      btn_enter = 1'b0;
      btn_bksp  = 1'b0;
      repeat (10) @(negedge clk);
   endtask

   task automatic dig(input int d);
      logic [12:0] v;
      v = 13'd1 << d;
      press(v);
   endtask

   task automatic chk_val(input string tag, input int v, input int c);
      chk({tag, "_value"}, int'(value), v);
      chk({tag, "_cnt"}, int'(digit_cnt), c);
   endtask

   initial begin
      repeat (3) @(negedge clk);
      chk("rst_value", int'(value), 0);
      chk("rst_cnt", int'(digit_cnt), 0);
      chk("rst_full", int'(full), 0);
      chk("rst_ev", int'(entry_valid), 0);
      chk("rst_evval", int'(entry_value), 0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // 1,2,3,4 then enter
      dig(1); chk_val("d1", 1, 1);
      dig(2); chk_val("d12", 12, 2);
      dig(3); chk_val("d123", 123, 3);
      chk("full3", int'(full), 0);
      dig(4); chk_val("d1234", 1234, 4);
      chk("full4", int'(full), 1);
      e0 = ev_n;
      press(B_ENT);
      chk("ent1_pulses", ev_n - e0, 1);
      chk("ent1_val", int'(entry_value), 1234);
      chk("ent1_hold_value", int'(value), 1234);
      chk("ev_low", int'(entry_valid), 0);

      // 9999, extra digit ignored, clear keeps entry_value
      press(B_CLR);
      dig(9); dig(9); dig(9); dig(9);
      chk_val("d9999", 9999, 4);
      dig(5); chk_val("full_ign", 9999, 4);
      press(B_CLR);
      chk_val("clr", 0, 0);
      chk("clr_full", int'(full), 0);
      chk("clr_evval", int'(entry_value), 1234);
      e0 = ev_n;
      press(B_ENT);
      chk("ent_empty_pulses", ev_n - e0, 1);
      chk("ent_empty_val", int'(entry_value), 0);
      chk_val("ent_empty", 0, 0);

      // Leading zeros, simultaneous digits, glitch
      dig(0); chk_val("lead0", 0, 0);
      dig(0);
      dig(7); chk_val("d007", 7, 1);
      press(13'h0028);
      chk_val("multi_dig", 7, 1);
      btn_digit = 10'h020;
      repeat (2) @(negedge clk);
      btn_digit = '0;
      repeat (10) @(negedge clk);
      chk_val("glitch", 7, 1);

      // 42, double enter, then a new operand from HOLD
      press(B_CLR);
      dig(4); dig(2);
      e0 = ev_n;
      press(B_ENT);
      press(B_ENT);
      chk("ent42_pulses", ev_n - e0, 2);
      chk("ent42_val", int'(entry_value), 42);
      chk_val("hold42", 42, 2);
      dig(6); chk_val("hold_new", 6, 1);
      chk("hold_new_evval", int'(entry_value), 42);

      // Reset while 8 is held mid-debounce
      btn_digit = 10'h100;
      repeat (4) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_value", int'(value), 0);
      chk("arst_cnt", int'(digit_cnt), 0);
      chk("arst_full", int'(full), 0);
      chk("arst_ev", int'(entry_valid), 0);
      chk("arst_evval", int'(entry_value), 0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (12) @(negedge clk);
      btn_digit = '0;
      repeat (10) @(negedge clk);
      chk_val("held8", 8, 1);

`ifdef CALC_BKSP_EN
      press(B_CLR);
      dig(5); dig(6); dig(7);
      chk_val("d567", 567, 3);
      press(B_BKSP); chk_val("bk56", 56, 2);
      press(B_BKSP); chk_val("bk5", 5, 1);
      press(B_BKSP); chk_val("bk0", 0, 0);
      dig(3);
      press(B_ENT);
      press(B_BKSP); chk_val("bk_hold", 3, 1);
      chk("bk_hold_evval", int'(entry_value), 3);
`else
      press(B_BKSP); chk_val("bk_off", 8, 1);
`endif

      chk("ev_back_to_back", ev_dbl, 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/calc_digit_entry.md
Name: calc_digit_entry

Overview:
Keypad front end for the calculator. It debounces the ten decimal-digit buttons and the clear, enter and backspace buttons. It accumulates the digit presses into a binary operand of up to 4 decimal digits (0..9999) and presents it each cycle to the 7-segment display driver. An enter press produces a one-cycle strobe with the latched operand for the arithmetic unit.

Parameters:
DEBOUNCE_CYCLES, 10_000, number of consecutive clk cycles a changed button vector must stay stable before it is accepted (set to 4 in simulation)
MAX_DIGITS, 4, maximum decimal digits accepted per operand

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
btn_digit  input  10  raw digit buttons, bit i = digit i, asynchronous to clk
btn_clr  input  1  raw clear button
btn_enter  input  1  raw enter button
btn_bksp  input  1  raw backspace button (ignored unless CALC_BKSP_EN)
value  output  14  operand being entered, binary, feeds display driver
digit_cnt  output  3  digits currently held (0..MAX_DIGITS)
full  output  1  digit_cnt == MAX_DIGITS
entry_valid  output  1  one-cycle strobe on an accepted enter
entry_value  output  14  operand latched at the last enter

Behaviour:
- Reset: clock and reset are fixed as one clock, clk, with asynchronous active-low reset rst_n. rst_n low clears everything immediately: value=0, digit_cnt=0, full=0, entry_valid=0, entry_value=0, state=EMPTY, synchronizers, stable vector and debounce counter all 0.
- Input path: the 13-bit raw vector {bksp,enter,clr,digit[9:0]} passes through a 2-flop synchronizer.
- Debounce: a single counter covers the whole vector. If sync != stable, the counter increments. When the counter reaches DEBOUNCE_CYCLES-1, stable<=sync and the counter clears. If sync == stable, the counter clears.
- Press events: press = stable & ~stable_q. Each is a 1-cycle pulse per bit.
- Press priority within one cycle: clr > enter > bksp > digit.
- Multiple digit presses: if more than one digit bit pulses in the same cycle, all digit presses in that cycle are ignored.
- Latency: value, digit_cnt and entry_valid update on the clock edge following the press pulse.
- Button held through reset release: it is registered as exactly one press after debounce.
- Releases produce no events.
- FSM states:
  - EMPTY (digit_cnt=0, value=0)
  - ENTRY (1..MAX_DIGITS digits)
  - HOLD (operand entered; value still displayed)
- EMPTY:
  - digit 0: ignored (leading-zero suppression).
  - digit d>0: value=d, digit_cnt=1, go to ENTRY.
  - enter: entry_valid=1 with entry_value=0; stay in EMPTY.
- ENTRY:
  - digit with digit_cnt<MAX_DIGITS: value=value*10+d, digit_cnt+1.
  - digit when full: ignored; value unchanged.
  - enter: entry_value<=value, entry_valid=1, go to HOLD.
- HOLD:
  - digit: starts a new operand with the same rules as EMPTY (d>0 gives value=d, digit_cnt=1, go to ENTRY; 0 gives value=0, digit_cnt=0, go to EMPTY).
  - enter: re-strobes entry_valid with the same entry_value.
- clr in any state: value=0, digit_cnt=0, go to EMPTY. entry_value is kept.
- Arithmetic: value*10 is computed as (value<<3)+(value<<1) at 14 bits. The maximum result, 999*10+9=9999, fits; no saturation is needed.
- entry_valid: high for exactly one cycle per accepted enter; never high two cycles in a row.

Optional Feature:
CALC_BKSP_EN
- Defined:
  - bksp in ENTRY: value=value/10, digit_cnt-1. If the result is digit_cnt 0, go to EMPTY.
  - bksp in EMPTY or HOLD: ignored.
- Undefined: btn_bksp is ignored and its synchronizer and debounce bit are not instantiated. The debounced vector is 12 bits.

Decomposition:
- calc_pkg holds:
  - VAL_W=14
  - MAX_VALUE=9999
  - entry_state_t enum {EMPTY, ENTRY, HOLD}
  - button index localparams (DIG0..DIG9, CLR, ENT, BKSP)
- Sub-module calc_debounce: parameterized width and DEBOUNCE_CYCLES. Contains the synchronizer, shared counter, stable register and press-pulse output. It is reusable for the operator buttons.

Test Plan:
- Enter 1,2,3,4 then enter (DEBOUNCE_CYCLES=4) -> value 1→12→123→1234, digit_cnt 4, full=1; entry_valid one cycle, entry_value=1234.
- With 9,9,9,9 entered, press 5 -> value stays 9999, digit_cnt 4. Press clr -> value=0, EMPTY, entry_value unchanged.
- Press 0,0,7 from EMPTY -> value 7, digit_cnt 1. Digits 3 and 5 in the same cycle -> both ignored. Glitch shorter than DEBOUNCE_CYCLES -> no change.
- Enter 42, press enter twice, then press 6 -> two entry_valid pulses, both with entry_value=42; then value=6, digit_cnt=1.
- rst_n low while 8 is held mid-debounce -> all outputs 0 immediately. After release, value=8 exactly once.
- CALC_BKSP_EN: enter 5,6,7 then bksp twice -> 56, then 5. A third bksp -> 0, EMPTY. bksp in HOLD -> no change.
